// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - colour type, transparent colour and default palette for sprite_palette_mapper
package sprite_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam rgb_t TRANSP_RGB = rgb_t'(24'hFFFFFF);

  localparam logic [0:7][23:0] DEFAULT_PAL = {
    24'hECECEC, 24'h091821, 24'h5AC6FF, 24'h295A7B,
    24'h4A9CD6, 24'h091821, 24'h3A7BA5, 24'h183952
  };

  // Palettes deeper than 8 entries repeat the table modulo 8.
  function automatic rgb_t default_colour(input logic [2:0] idx);
    return rgb_t'(DEFAULT_PAL[idx]);
  endfunction

endpackage

// File: rtl/palette_bank.sv
// rtl/palette_bank.sv - NUM_PAL x 2**IDX_W palette register file, one write port, one registered read port
module palette_bank
  import sprite_pkg::*;
#(
  parameter int NUM_PAL = 2,
  parameter int IDX_W   = 3,
  parameter int PSEL_W  = 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              we,
  input  logic [PSEL_W-1:0] wsel,
  input  logic [IDX_W-1:0]  widx,
  input  rgb_t              wdata,
  input  logic              rd_en,
  input  logic [PSEL_W-1:0] rd_sel,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic              rd_white,
  output rgb_t              rd_data
);

  localparam int DEPTH = 1 << IDX_W;

  rgb_t mem [NUM_PAL][DEPTH];
  logic wsel_ok;

  assign wsel_ok = int'(wsel) < NUM_PAL;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int p = 0; p < NUM_PAL; p++) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem[p][i] <= default_colour(3'(i));
        end
      end
    end else if (we && wsel_ok) begin
      mem[wsel][widx] <= wdata;
    end
  end

  // Reads see the pre-write contents when a write hits the same entry.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_white ? TRANSP_RGB : mem[rd_sel][rd_idx];
    end
  end

endmodule

// File: rtl/sprite_palette_mapper.sv
// rtl/sprite_palette_mapper.sv - 2-stage sprite index to RGB mapper; hit flash enabled by SPRITE_HIT_FLASH_EN
module sprite_palette_mapper
  import sprite_pkg::*;
#(
  parameter int ADDR_W       = 19,
  parameter int IDX_W        = 3,
  parameter int NUM_PAL      = 2,
  parameter int TRANSP_IDX   = 0,
  parameter int FLASH_FRAMES = 8,
  localparam int PSEL_W      = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              pix_valid_in,
  input  logic [ADDR_W-1:0] address,
  input  logic [PSEL_W-1:0] pal_sel,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_idx,
  input  logic              pal_we,
  input  logic [PSEL_W-1:0] pal_wsel,
  input  logic [IDX_W-1:0]  pal_widx,
  input  logic [23:0]       pal_wdata,
  input  logic              hit_flash,
  input  logic              frame_start,
  output logic [7:0]        Red,
  output logic [7:0]        Green,
  output logic [7:0]        Blue,
  output logic              zero,
  output logic              pix_valid_out
);

  logic              s1_valid;
  logic [PSEL_W-1:0] s1_sel;
  logic              transp;
  logic              flash_white;
  rgb_t              rd_data;

  assign rom_addr = address;
  assign transp   = (rom_idx == IDX_W'(TRANSP_IDX));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid <= 1'b0;
      s1_sel   <= '0;
    end else begin
      s1_valid <= pix_valid_in;
      s1_sel   <= (int'(pal_sel) < NUM_PAL) ? pal_sel : '0;
    end
  end

`ifdef SPRITE_HIT_FLASH_EN
  localparam int FLASH_W = $clog2(FLASH_FRAMES + 1);
  logic [FLASH_W-1:0] flash_cnt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      flash_cnt <= '0;
    end else if (hit_flash) begin
      flash_cnt <= FLASH_W'(FLASH_FRAMES);
    end else if (frame_start && flash_cnt != '0) begin
      flash_cnt <= flash_cnt - 1'b1;
    end
  end

  assign flash_white = (flash_cnt != '0) && flash_cnt[0];
`else
  localparam int UNUSED_FLASH_FRAMES = FLASH_FRAMES;
  logic unused_flash;
  assign unused_flash = hit_flash ^ frame_start;
  assign flash_white  = 1'b0;
`endif

  // Transparent pixels and flash-on opaque pixels both read back as white.
  palette_bank #(
    .NUM_PAL (NUM_PAL),
    .IDX_W   (IDX_W),
    .PSEL_W  (PSEL_W)
  ) u_bank (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .we       (pal_we),
    .wsel     (pal_wsel),
    .widx     (pal_widx),
    .wdata    (rgb_t'(pal_wdata)),
    .rd_en    (s1_valid),
    .rd_sel   (s1_sel),
    .rd_idx   (rom_idx),
    .rd_white (transp | flash_white),
    .rd_data  (rd_data)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pix_valid_out <= 1'b0;
      zero          <= 1'b0;
    end else begin
      pix_valid_out <= s1_valid;
      if (s1_valid) begin
        zero <= transp;
      end
    end
  end

  assign Red   = rd_data.r;
  assign Green = rd_data.g;
  assign Blue  = rd_data.b;

endmodule
